cpu_controller: RTL and testbench
=================================

# cpu_controller

Sequencing control unit for the simple 12-bit processor. It consumes the word held in the instruction register, decodes it, and steps the datapath through fetch, decode and execute. Per instruction it drives the IR load and source select, the PC increment, the register-file ports, the ALU op and the data-memory write. It sits between the instruction register and the datapath (register file, ALU, data memory) and executes one instruction per `start` pulse.

## Interface
Parameters:
- `RF_AW`, default 3: register-file address width (8 registers).
- `DM_AW`, default 4: data-memory address width (16 words).

Ports:
- `clk` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: reset is synchronous and active-low; sampled on the rising edge of `clk`.
- `start` input 1: one-cycle pulse that requests execution of one instruction.
- `mode` input 1: instruction source. 0 = instruction memory, which also increments the PC. 1 = switches.
- `ir` input 12: current instruction-register contents.
- `ir_ld` output 1: IR load enable.
- `ir_sel` output 1: IR source select, driven to the `mode` value captured at `start`.
- `pc_en` output 1: PC increment.
- `rf_we` output 1: register-file write enable.
- `rf_wsel` output 1: write-data select. 0 = ALU, 1 = data memory.
- `rf_waddr` output RF_AW: register-file write address.
- `rf_raddr_a` output RF_AW: register-file read port A address.
- `rf_raddr_b` output RF_AW: register-file read port B address.
- `alu_op` output 1: 0 = add, 1 = subtract (A−B).
- `dm_addr` output DM_AW: data-memory address.
- `dm_we` output 1: data-memory write enable.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in the final state of each instruction.

## Operation
Instruction format:
- `ir[11:9]` is the opcode.
- LOAD, opcode 000: R[`ir[6:4]`] ← DM[`ir[3:0]`].
- STORE, opcode 001: DM[`ir[3:0]`] ← R[`ir[6:4]`].
- ADD, opcode 101: R[`ir[8:6]`] ← R[`ir[5:3]`] + R[`ir[2:0]`].
- SUB, opcode 110: R[`ir[8:6]`] ← R[`ir[5:3]`] − R[`ir[2:0]`]. Wrap-around is modulo the datapath width; this block does no arithmetic itself.
- Any other opcode is a NOP.

FSM states and transitions:
- IDLE → FETCH when `start` = 1. `mode` is captured into `mode_q` at this edge.
- FETCH → DECODE.
- DECODE → MEMRD (LOAD), STORE (STORE), ALU (ADD/SUB) or NOP (other opcodes).
- MEMRD → WB.
- WB, STORE, ALU and NOP each → IDLE.

Outputs per state (Moore; all outputs default to 0):
- FETCH: `ir_ld` = 1, `ir_sel` = `mode_q`, `pc_en` = ¬`mode_q`.
- DECODE: latches opcode and all fields from `ir`. Later states use only the latched copies, so `ir` changes after DECODE have no effect.
- MEMRD: `dm_addr` = addr field.
- WB: `dm_addr` = addr field, `rf_wsel` = 1, `rf_waddr` = reg field, `rf_we` = 1, `done` = 1.
- STORE: `dm_addr` = addr field, `rf_raddr_a` = reg field, `dm_we` = 1, `done` = 1.
- ALU: `rf_raddr_a` = ra, `rf_raddr_b` = rb, `rf_waddr` = rd, `alu_op` = (opcode == 110), `rf_we` = 1, `done` = 1.
- NOP: `done` = 1 only.

Boundary conditions:
- `start` while `busy` is ignored; it is not queued.
- `start` held high for several cycles starts a second instruction only if it is still high in IDLE after `done`.
- `mode` changes after the capture edge have no effect on the current instruction.
- `reset` low at any edge: next state IDLE, every output 0, latched fields cleared. Partial writes are never issued after reset.

## Timing
Start is the cycle in which `start` = 1 is sampled in IDLE (cycle 0):
- Cycle 1: FETCH. `ir` is valid from cycle 2.
- Cycle 2: DECODE.
- Cycle 3: MEMRD for LOAD, or the final state for STORE, ADD, SUB and NOP.
- Cycle 4: WB for LOAD.

Latency is 3 cycles from `start` to `done` for STORE, ALU and NOP, and 4 cycles for LOAD. The next `start` is accepted from the cycle after `done`. Data memory is synchronous-read with 1-cycle latency, which is why MEMRD precedes WB.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - `state_t` enum (IDLE, FETCH, DECODE, MEMRD, WB, STORE, ALU, NOP).
  - Opcode localparams `OP_LOAD` = 3'b000, `OP_STORE` = 3'b001, `OP_ADD` = 3'b101, `OP_SUB` = 3'b110.
  - `ALU_ADD` = 0, `ALU_SUB` = 1.
- One sub-module, `instr_decode`: combinational field extraction from the 12-bit word (opcode, rd, ra, rb, reg, addr, is_load/is_store/is_alu).
- The FSM and field latches live in `cpu_controller`.

## Test plan
- Reset: hold `reset` low 2 cycles → every output 0, `busy` = 0.
- LOAD, `mode` = 0, `ir` = 0x035:
  - cycle 1: `ir_ld` = 1, `pc_en` = 1.
  - cycle 3: `dm_addr` = 5.
  - cycle 4: `rf_we` = 1, `rf_wsel` = 1, `rf_waddr` = 3, `done` = 1.
- STORE `ir` = 0x27C and ADD `ir` = 0xA1A, `mode` = 1:
  - `pc_en` = 0 and `ir_sel` = 1 in FETCH.
  - STORE cycle 3: `dm_we` = 1, `dm_addr` = 12, `rf_raddr_a` = 7.
  - ADD cycle 3: `rf_raddr_a` = 3, `rf_raddr_b` = 2, `rf_waddr` = 0, `alu_op` = 0, `rf_we` = 1.
- SUB `ir` = 0xDD1 → cycle 3: `alu_op` = 1, `rf_waddr` = 7, `rf_raddr_a` = 2, `rf_raddr_b` = 1.
- NOP `ir` = 0x600 → `done` in cycle 3; `rf_we` and `dm_we` never asserted.
- Robustness:
  - `start` pulses in cycles 1–3 of a LOAD are ignored, giving exactly one `done`.
  - `reset` low in cycle 3 of a LOAD → IDLE next cycle, and `rf_we` is never asserted.
  - Changing `ir` during cycle 3 does not alter the cycle-4 outputs.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the 12-bit processor control unit.
// Imported by the instruction decoder and the sequencing FSM.
package cpu_ctrl_pkg;

    localparam int IR_W  = 12;
    localparam int OP_W  = 3;
    localparam int FLD_W = 3;
    localparam int ADR_W = 4;

    localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OP_W-1:0] OP_STORE = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b110;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEMRD  = 3'd3,
        WB     = 3'd4,
        STORE  = 3'd5,
        ALU    = 3'd6,
        NOP    = 3'd7
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [FLD_W-1:0] rd;
        logic [FLD_W-1:0] ra;
        logic [FLD_W-1:0] rb;
        logic [FLD_W-1:0] rg;
        logic [ADR_W-1:0] addr;
        logic             is_load;
        logic             is_store;
        logic             is_alu;
    } fields_t;

    function automatic logic alu_sel(input logic [OP_W-1:0] op);
        return (op == OP_SUB) ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/cpu_controller_instr_decode.sv
// Combinational field extraction for one 12-bit instruction word.
// Class flags are one-hot or all-zero (NOP).
import cpu_ctrl_pkg::*;

module instr_decode (
    input  logic [IR_W-1:0] ir,
    output fields_t         f
);

    always_comb begin
        f          = '0;
        f.opcode   = ir[11:9];
        f.rd       = ir[8:6];
        f.ra       = ir[5:3];
        f.rb       = ir[2:0];
        f.rg       = ir[6:4];
        f.addr     = ir[3:0];
        case (ir[11:9])
            OP_LOAD:  f.is_load  = 1'b1;
            OP_STORE: f.is_store = 1'b1;
            OP_ADD,
            OP_SUB:   f.is_alu   = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Sequencing FSM: fetch, decode and execute one instruction per start.
// Fields are latched in DECODE so later ir changes cannot disturb execution.
import cpu_ctrl_pkg::*;

module cpu_controller #(
    parameter int RF_AW = 3,
    parameter int DM_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [11:0]      ir,
    output logic             ir_ld,
    output logic             ir_sel,
    output logic             pc_en,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [RF_AW-1:0] rf_raddr_a,
    output logic [RF_AW-1:0] rf_raddr_b,
    output logic             alu_op,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_we,
    output logic             busy,
    output logic             done
);

    state_t  state;
    state_t  state_n;
    logic    mode_q;
    fields_t dec;
    fields_t lat;

    instr_decode u_dec (
        .ir (ir),
        .f  (dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            lat    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                mode_q <= mode;
            end
            if (state == DECODE) begin
                lat <= dec;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (start) state_n = FETCH;
            FETCH:  state_n = DECODE;
            DECODE: begin
                unique case (1'b1)
                    dec.is_load:  state_n = MEMRD;
                    dec.is_store: state_n = STORE;
                    dec.is_alu:   state_n = ALU;
                    default:      state_n = NOP;
                endcase
            end
            MEMRD:  state_n = WB;
            WB,
            STORE,
            ALU,
            NOP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Moore outputs: only state and latched fields, never live ir/mode.
    always_comb begin
        ir_ld      = 1'b0;
        ir_sel     = 1'b0;
        pc_en      = 1'b0;
        rf_we      = 1'b0;
        rf_wsel    = 1'b0;
        rf_waddr   = '0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        alu_op     = ALU_ADD;
        dm_addr    = '0;
        dm_we      = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        unique case (state)
            FETCH: begin
                ir_ld  = 1'b1;
                ir_sel = mode_q;
                pc_en  = ~mode_q;
            end
            MEMRD: begin
                dm_addr = DM_AW'(lat.addr);
            end
            WB: begin
                dm_addr  = DM_AW'(lat.addr);
                rf_wsel  = 1'b1;
                rf_waddr = RF_AW'(lat.rg);
                rf_we    = 1'b1;
                done     = 1'b1;
            end
            STORE: begin
                dm_addr    = DM_AW'(lat.addr);
                rf_raddr_a = RF_AW'(lat.rg);
                dm_we      = 1'b1;
                done       = 1'b1;
            end
            ALU: begin
                rf_raddr_a = RF_AW'(lat.ra);
                rf_raddr_b = RF_AW'(lat.rb);
                rf_waddr   = RF_AW'(lat.rd);
                alu_op     = alu_sel(lat.opcode);
                rf_we      = 1'b1;
                done       = 1'b1;
            end
            NOP: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller; expected outputs hand-derived
// from the instruction encodings.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] ir = '0;
    logic        ir_ld, ir_sel, pc_en, rf_we, rf_wsel;
    logic [2:0]  rf_waddr, rf_raddr_a, rf_raddr_b;
    logic        alu_op, dm_we, busy, done;
    logic [3:0]  dm_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [21:0] got;
    logic [21:0] want;

    cpu_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .ir         (ir),
        .ir_ld      (ir_ld),
        .ir_sel     (ir_sel),
        .pc_en      (pc_en),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .rf_waddr   (rf_waddr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .alu_op     (alu_op),
        .dm_addr    (dm_addr),
        .dm_we      (dm_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {ir_ld, ir_sel, pc_en, rf_we, rf_wsel, rf_waddr,
                rf_raddr_a, rf_raddr_b, alu_op, dm_addr, dm_we,
                busy, done};
    endfunction

    function automatic logic [21:0] ev(
        input logic ld, sel, pc, we, wsel,
        input logic [2:0] wa, a, b,
        input logic op,
        input logic [3:0] da,
        input logic dwe, bsy, dn
    );
        return {ld, sel, pc, we, wsel, wa, a, b, op, da, dwe, bsy, dn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = obs();
            n_cmp++;
            if (got !== 22'h0) begin
                n_bad++;
                $display("FAIL reset_%0d got=%h want=%h", i, got, 22'h0);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_load();
        start = 1'b1; mode = 1'b0; ir = 12'h035;
        step();
        start = 1'b0;
        got = obs(); want = ev(1,0,1,0,0,0,0,0,0,0,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL load_c1 got=%h want=%h", got, want);
        end
        step();
        got = obs(); want = ev(0,0,0,0,0,0,0,0,0,0,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL load_c2 got=%h want=%h", got, want);
        end
        step();
        got = obs(); want = ev(0,0,0,0,0,0,0,0,0,4'd5,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL load_c3 got=%h want=%h", got, want);
        end
        ir = 12'hFFF;
        step();
        got = obs(); want = ev(0,0,0,1,1,3'd3,0,0,0,4'd5,0,1,1);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL load_c4 got=%h want=%h", got, want);
        end
        step();
        got = obs();
        n_cmp++;
        if (got !== 22'h0) begin
            n_bad++; $display("FAIL load_idle got=%h want=%h", got, 22'h0);
        end
    endtask

    task automatic test_store();
        start = 1'b1; mode = 1'b1; ir = 12'h27C;
        step();
        start = 1'b0;
        mode = 1'b0;
        #1;
        got = obs(); want = ev(1,1,0,0,0,0,0,0,0,0,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL store_c1 got=%h want=%h", got, want);
        end
        step();
        step();
        got = obs(); want = ev(0,0,0,0,0,0,3'd7,0,0,4'd12,1,1,1);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL store_c3 got=%h want=%h", got, want);
        end
        step();
        got = obs();
        n_cmp++;
        if (got !== 22'h0) begin
            n_bad++; $display("FAIL store_idle got=%h want=%h", got, 22'h0);
        end
    endtask

    task automatic test_add();
        start = 1'b1; mode = 1'b1; ir = 12'hA1A;
        step();
        start = 1'b0;
        got = obs(); want = ev(1,1,0,0,0,0,0,0,0,0,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL add_c1 got=%h want=%h", got, want);
        end
        step();
        step();
        got = obs(); want = ev(0,0,0,1,0,3'd0,3'd3,3'd2,0,0,0,1,1);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL add_c3 got=%h want=%h", got, want);
        end
        step();
    endtask

    task automatic test_sub();
        start = 1'b1; mode = 1'b0; ir = 12'hDD1;
        step();
        start = 1'b0;
        got = obs(); want = ev(1,0,1,0,0,0,0,0,0,0,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL sub_c1 got=%h want=%h", got, want);
        end
        step();
        step();
        got = obs(); want = ev(0,0,0,1,0,3'd7,3'd2,3'd1,1,0,0,1,1);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL sub_c3 got=%h want=%h", got, want);
        end
        step();
    endtask

    task automatic test_nop();
        int writes;
        writes = 0;
        start = 1'b1; mode = 1'b0; ir = 12'h600;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (rf_we || dm_we) writes++;
            if (c == 3) begin
                got = obs(); want = ev(0,0,0,0,0,0,0,0,0,0,0,1,1);
                n_cmp++;
                if (got !== want) begin
                    n_bad++; $display("FAIL nop_c3 got=%h want=%h", got, want);
                end
            end
            step();
        end
        n_cmp++;
        if (writes !== 0) begin
            n_bad++; $display("FAIL nop_writes got=%0d want=0", writes);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int wes;
        dones = 0;
        wes = 0;
        start = 1'b1; mode = 1'b0; ir = 12'h035;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c >= 4) start = 1'b0;
            if (done) dones++;
            if (rf_we) wes++;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++; $display("FAIL b2b_done got=%0d want=1", dones);
        end
        n_cmp++;
        if (wes !== 1) begin
            n_bad++; $display("FAIL b2b_we got=%0d want=1", wes);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_held_start();
        start = 1'b1; mode = 1'b0; ir = 12'h600;
        for (int c = 1; c <= 4; c++) step();
        got = obs();
        n_cmp++;
        if (got !== 22'h0) begin
            n_bad++; $display("FAIL held_c4 got=%h want=%h", got, 22'h0);
        end
        step();
        start = 1'b0;
        got = obs(); want = ev(1,0,1,0,0,0,0,0,0,0,0,1,0);
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL held_c5 got=%h want=%h", got, want);
        end
        for (int c = 6; c <= 8; c++) step();
        got = obs();
        n_cmp++;
        if (got !== 22'h0) begin
            n_bad++; $display("FAIL held_c8 got=%h want=%h", got, 22'h0);
        end
    endtask

    task automatic test_reset_mid();
        int wes;
        wes = 0;
        start = 1'b1; mode = 1'b0; ir = 12'h035;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        got = obs();
        n_cmp++;
        if (got !== 22'h0) begin
            n_bad++; $display("FAIL rstmid_c4 got=%h want=%h", got, 22'h0);
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (rf_we) wes++;
            step();
        end
        n_cmp++;
        if (wes !== 0) begin
            n_bad++; $display("FAIL rstmid_we got=%0d want=0", wes);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_busy got=%b want=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_add();
        test_sub();
        test_nop();
        test_back_to_back();
        test_held_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
